// File: rtl/prog_loader_pkg.sv
// Shared constants and FSM state type for the program loader.
//   WORD_W : instruction word width delivered to the CPU
//   ADDR_W : instruction-memory address width (also the word-count width)
//   BYTE_W : host link byte width
package prog_loader_pkg;

  localparam int unsigned WORD_W = 19;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StB0,
    StB1,
    StB2,
    StWrite,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream from the host link and
// writes little-endian 19-bit instruction words into CPU instruction memory,
// then enables the CPU.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   start     : pulse that begins a load session (honoured in IDLE, DONE, ERR)
//   in_data   : host byte
//   in_valid  : in_data valid
//   in_ready  : loader accepts a byte this cycle
//   we_IM     : instruction-memory write strobe
//   codein    : instruction word being written
//   prog_addr : write address
//   cpu_en    : CPU run enable (DONE only)
//   busy      : session in progress
//   err       : sticky format-error flag, cleared by an accepted start
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we_IM,
  output logic [WORD_W-1:0] codein,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              cpu_en,
  output logic              busy,
  output logic              err
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] codein_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic              err_q;

  logic              accept;
  logic              start_ok;
  logic              bad_top;
  logic [ADDR_W-1:0] len_word;

  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  // Only byte[2:0] of the third byte carries word bits; anything above is malformed.
  assign bad_top  = |in_data[BYTE_W-1:WORD_W-2*BYTE_W];
  // Low length byte is parked in count_q[7:0] until the high byte arrives.
  assign len_word = {in_data[5:0], count_q[7:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLenLo;
      StLenLo: if (accept) state_d = StLenHi;
      StLenHi: if (accept) state_d = (len_word == '0) ? StDone : StB0;
      StB0:    if (accept) state_d = StB1;
      StB1:    if (accept) state_d = StB2;
      StB2:    if (accept) state_d = bad_top ? StErr : StWrite;
      StWrite: state_d = (count_q == ADDR_W'(1)) ? StDone : StB0;
      StDone:  if (start) state_d = StLenLo;
      StErr:   if (start) state_d = StLenLo;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded straight from state so reset kills them without waiting for a clock.
  always_comb begin
    in_ready = 1'b0;
    we_IM    = 1'b0;
    cpu_en   = 1'b0;
    busy     = 1'b1;
    case (state_q)
      StLenLo, StLenHi, StB0, StB1, StB2: in_ready = 1'b1;
      StWrite:                            we_IM    = 1'b1;
      default:                            ;
    endcase
    if (state_q == StDone) cpu_en = 1'b1;
    if ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr)) busy = 1'b0;
  end

  // Byte assembler, address/count counters and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codein_q <= '0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q  <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end
      case (state_q)
        StLenLo: if (accept) count_q[BYTE_W-1:0] <= in_data;
        StLenHi: begin
          if (accept) begin
            count_q <= len_word;
            addr_q  <= '0;
          end
        end
        StB0: if (accept) codein_q[BYTE_W-1:0] <= in_data;
        StB1: if (accept) codein_q[2*BYTE_W-1:BYTE_W] <= in_data;
        StB2: begin
          if (accept) begin
            if (bad_top) begin
              err_q <= 1'b1;
            end else begin
              codein_q[WORD_W-1:2*BYTE_W] <= in_data[WORD_W-2*BYTE_W-1:0];
            end
          end
        end
        StWrite: begin
          // Address wraps naturally at 2^ADDR_W.
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_q - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign codein    = codein_q;
  assign prog_addr = addr_q;
  assign err       = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port start  input  1  one-cycle pulse beginning a load session.
REQ-004 SHALL have port in_data  input  8  byte stream from the host link.
REQ-005 SHALL have port in_valid  input  1  in_data valid.
REQ-006 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-007 SHALL have port we_IM  output  1  instruction-memory write strobe to the CPU.
REQ-008 SHALL have port codein  output  19  instruction word to the CPU.
REQ-009 SHALL have port prog_addr  output  14  write address; drives the CPU immd/instruction-address path.
REQ-010 SHALL have port cpu_en  output  1  CPU run enable.
REQ-011 SHALL have port busy  output  1  session in progress.
REQ-012 SHALL have port err  output  1  sticky format-error flag.

Function
REQ-013 SHALL transfer a byte only on a cycle where in_valid and in_ready are both high.
REQ-014 SHALL use states IDLE, LEN_LO, LEN_HI, B0, B1, B2, WRITE, DONE, ERR.
REQ-015 SHALL move IDLE->LEN_LO on start; start SHALL be ignored in every state except IDLE, DONE and ERR.
REQ-016 SHALL, in LEN_LO/LEN_HI, capture the word count N as {byte1[5:0], byte0}; byte1[7:6] SHALL be ignored.
REQ-017 SHALL go LEN_HI->DONE when N==0, otherwise LEN_HI->B0 with prog_addr=0.
REQ-018 SHALL assemble each word little-endian: B0 gives codein[7:0], B1 gives [15:8], B2 gives [18:16] from byte[2:0].
REQ-019 SHALL go B2->ERR when byte[7:3] of the third byte is non-zero; no write SHALL occur for that word.
REQ-020 SHALL go B2->WRITE otherwise; WRITE SHALL last exactly one cycle with we_IM=1 and codein/prog_addr stable.
REQ-021 SHALL hold in_ready=1 only in LEN_LO, LEN_HI, B0, B1 and B2.
REQ-022 SHALL increment prog_addr and decrement the remaining count at the end of WRITE, then go to DONE if remaining reaches 0, else to B0.
REQ-023 SHALL allow prog_addr to wrap 16383->0 without error; with N at most 16383, wrap never aliases within one session.
REQ-024 SHALL assert cpu_en only in DONE, from the cycle after the last WRITE; cpu_en SHALL be 0 in all other states.
REQ-025 SHALL assert busy in every state other than IDLE, DONE and ERR.
REQ-026 SHALL set err on entry to ERR; err SHALL stay set until the next accepted start, which clears it.
REQ-027 SHALL, on start in DONE or ERR, drop cpu_en, go to LEN_LO, and reload from address 0.
REQ-028 SHALL ignore in_valid stalls: the state is held and no timeout applies.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE and in_ready, we_IM, cpu_en, busy, err=0.
REQ-030 SHALL, while rst_n=0, force codein=0, prog_addr=0 and the count=0.
REQ-031 SHALL, on reset during WRITE, suppress the write immediately, because of the asynchronous assert.
REQ-032 SHALL leave memory contents already written untouched by reset.

Structure
REQ-033 SHALL take the state enum and constants WORD_W=19, ADDR_W=14 and BYTE_W=8 from the shared CPU package.
REQ-034 SHALL be a single module with no sub-modules; the FSM, byte assembler and address/count counters are inline.

Verification
REQ-035 SHALL cover: start, bytes 02 00 | 34 12 05 | FF FF 07 -> writes 0x51234@0 and 0x7FFFF@1, then cpu_en=1 the cycle after the second we_IM.
REQ-036 SHALL cover: start, bytes 00 00 -> DONE, cpu_en=1, no we_IM pulse.
REQ-037 SHALL cover: N=1, third byte 0x0D -> err=1, state ERR, no we_IM, cpu_en=0; a new start clears err.
REQ-038 SHALL cover: in_valid toggled randomly during N=3 -> identical writes at addresses 0..2; in_ready low during each WRITE.
REQ-039 SHALL cover: rst_n low in the middle of B1 -> all outputs 0 at once; after release a fresh start loads correctly from address 0.
REQ-040 SHALL cover: start pulsed during B0 -> ignored, session completes unchanged.
